alog_seq_ctrl: RTL and testbench



---
 rtl/alog_pkg.sv | 16 +
 rtl/alog_seq_ctrl_if.sv | 32 +++
 rtl/alog_phase_cnt.sv | 41 ++++
 rtl/alog_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_alog_seq_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alog_pkg.sv
// rtl/alog_pkg.sv - shared state encodings and widths for the adaptive-filter blocks
package alog_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE = 5'b00001;
  localparam state_t S_FILT = 5'b00010;
  localparam state_t S_WCAL = 5'b00100;
  localparam state_t S_SHFT = 5'b01000;
  localparam state_t S_WAIT = 5'b10000;

  localparam int TAPS_DEF = 16;
  localparam int DATA_W   = 14;
  localparam int WEIGHT_W = 32;

endpackage

// File: rtl/alog_seq_ctrl_if.sv
// rtl/alog_seq_ctrl_if.sv - control/status bundle between upstream logic and the phase sequencer
interface alog_seq_ctrl_if
  import alog_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int FCNT_W = 16
);

  logic                    head_flag;
  logic                    stall;
  logic                    clr;
  logic                    adap_filter_state;
  logic                    weight_cal_state;
  logic                    shift_data_state;
  logic [$clog2(TAPS)-1:0] tap_idx;
  logic                    busy;
  logic                    done;
  logic [FCNT_W-1:0]       frame_cnt;

  modport master (
    output head_flag, stall, clr,
    input  adap_filter_state, weight_cal_state, shift_data_state,
    input  tap_idx, busy, done, frame_cnt
  );

  modport slave (
    input  head_flag, stall, clr,
    output adap_filter_state, weight_cal_state, shift_data_state,
    output tap_idx, busy, done, frame_cnt
  );

endinterface

// File: rtl/alog_phase_cnt.sv
// rtl/alog_phase_cnt.sv - loadable down-counter with hold and terminal-count flag
module alog_phase_cnt
  import alog_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; neither asserted means hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/alog_seq_ctrl.sv
// rtl/alog_seq_ctrl.sv - FILT/WCAL/SHFT phase sequencer; ALOG_SEQ_CONT_EN enables back-to-back frames
module alog_seq_ctrl
  import alog_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int WCAL_CYC = 1,
  parameter int SHFT_CYC = 1,
  parameter int FCNT_W   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  alog_seq_ctrl_if.slave  seq
);

  localparam int TW = $clog2(TAPS);
  localparam int CW = (TW > 4) ? TW : 4;

  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);
  localparam logic [CW-1:0] WCAL_M1 = CW'(WCAL_CYC - 1);
  localparam logic [CW-1:0] SHFT_M1 = CW'(SHFT_CYC - 1);

  state_t            state_q;
  state_t            state_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CW-1:0]     cnt_val;
  logic [CW-1:0]     cnt;
  logic              cnt_tc;
  logic              done;
  logic [FCNT_W-1:0] frame_cnt_q;

  // One counter serves every phase; it is reloaded on each phase entry.
  alog_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter control; clr beats stall, stall freezes everything.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (seq.clr) begin
      state_d  = S_IDLE;
      cnt_load = 1'b1;
    end else if (!seq.stall) begin
      case (state_q)
        S_IDLE: begin
          if (seq.head_flag) begin
            state_d  = S_FILT;
            cnt_load = 1'b1;
            cnt_val  = TAPS_M1;
          end
        end
        S_FILT: begin
          if (cnt_tc) begin
            state_d  = S_WCAL;
            cnt_load = 1'b1;
            cnt_val  = WCAL_M1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_WCAL: begin
          if (cnt_tc) begin
            state_d  = S_SHFT;
            cnt_load = 1'b1;
            cnt_val  = SHFT_M1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_SHFT: begin
          if (cnt_tc) begin
`ifdef ALOG_SEQ_CONT_EN
            if (seq.head_flag) begin
              state_d  = S_FILT;
              cnt_load = 1'b1;
              cnt_val  = TAPS_M1;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_WAIT;
`endif
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_WAIT: begin
          // A level still high from the last frame must drop before retriggering.
          if (!seq.head_flag) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  // Output decode: enables gated by stall, busy ungated, tap index counts up.
  always_comb begin
    seq.adap_filter_state = state_q[1] & ~seq.stall;
    seq.weight_cal_state  = state_q[2] & ~seq.stall;
    seq.shift_data_state  = state_q[3] & ~seq.stall;
    seq.busy              = state_q[1] | state_q[2] | state_q[3];
    seq.tap_idx           = '0;
    if (state_q == S_FILT) begin
      seq.tap_idx = TW'(TAPS_M1 - cnt);
    end
    done          = state_q[3] & cnt_tc & ~seq.stall;
    seq.done      = done;
    seq.frame_cnt = frame_cnt_q;
  end

  // Completed-frame counter, saturating; survives clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else if (done && (frame_cnt_q != '1)) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alog_seq_ctrl.sv
// tb/tb_alog_seq_ctrl.sv - directed self-checking bench for alog_seq_ctrl
module tb_alog_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alog_seq_ctrl_if #(.TAPS(16), .FCNT_W(16)) sif ();
  alog_seq_ctrl_if #(.TAPS(4),  .FCNT_W(4))  sat_if ();

  alog_seq_ctrl #(.TAPS(16), .WCAL_CYC(1), .SHFT_CYC(1), .FCNT_W(16)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .seq  (sif.slave)
  );

  alog_seq_ctrl #(.TAPS(4), .WCAL_CYC(1), .SHFT_CYC(1), .FCNT_W(4)) u_sat (
    .clk  (clk),
    .rstn (rstn),
    .seq  (sat_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a frame (call just after a negedge, DUT idle) and follows it to the cycle after done.
  task automatic run_frame(input int stall_tap, input int stall_len,
                           output int afs_n, output int wcal_n, output int shft_n,
                           output int done_cyc, output int tap_err, output int gate_err);
    int exp_tap;
    int left;
    bit stalled;
    afs_n = 0; wcal_n = 0; shft_n = 0; done_cyc = -1; tap_err = 0; gate_err = 0;
    exp_tap = 0;
    left = stall_len;
    sif.head_flag = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      stalled = (left > 0) && sif.busy && (int'(sif.tap_idx) == stall_tap);
      sif.stall = stalled;
      if (stalled) left--;
      #1;
      if (done_cyc >= 0) break;
      if (sif.adap_filter_state) begin
        if (int'(sif.tap_idx) != exp_tap) tap_err++;
        exp_tap++;
        afs_n++;
      end
      if (stalled && (sif.adap_filter_state || sif.weight_cal_state ||
                      sif.shift_data_state || sif.done)) gate_err++;
      if (stalled && (int'(sif.tap_idx) != stall_tap)) tap_err++;
      if ($countones({sif.adap_filter_state, sif.weight_cal_state, sif.shift_data_state}) > 1)
        gate_err++;
      wcal_n += int'(sif.weight_cal_state);
      shft_n += int'(sif.shift_data_state);
      if (sif.done) done_cyc = cyc;
    end
    sif.stall = 1'b0;
  endtask

  // Drops head_flag and waits for the sequencer to settle back in IDLE.
  task automatic wait_idle();
    sif.head_flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!sif.busy) break;
    end
    chk("idle_reached", 32'(sif.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int a, w, s, d, te, ge;
    int busy_n;
    int sat_to;
    bit got;

    sif.head_flag = 0; sif.stall = 0; sif.clr = 0;
    sat_if.head_flag = 0; sat_if.stall = 0; sat_if.clr = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_en", 32'({sif.adap_filter_state, sif.weight_cal_state, sif.shift_data_state}), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_tap", 32'(sif.tap_idx), 0);
    chk("rst_fcnt", 32'(sif.frame_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;

    // First frame: 16 FILT, 1 WCAL, 1 SHFT with done
    run_frame(-1, 0, a, w, s, d, te, ge);
    exp_fc = 1;
    chk("f1_filt_cycles", a, 16);
    chk("f1_wcal_cycles", w, 1);
    chk("f1_shft_cycles", s, 1);
    chk("f1_done_cycle", d, 17);
    chk("f1_tap_seq", te, 0);
    chk("f1_onehot", ge, 0);
    chk("f1_fcnt", 32'(sif.frame_cnt), 1);
`ifndef ALOG_SEQ_CONT_EN
    chk("f1_wait_busy", 32'(sif.busy), 0);
    busy_n = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      #1;
      busy_n += int'(sif.busy);
    end
    chk("hold_no_retrigger", busy_n, 0);
    chk("hold_fcnt", 32'(sif.frame_cnt), 1);
`else
    chk("cont_b2b_filt", 32'({sif.adap_filter_state, sif.tap_idx}), 32'({1'b1, 4'd0}));
    exp_fc = 2;
`endif

    // Second frame after a low phase on head_flag
    wait_idle();
    run_frame(-1, 0, a, w, s, d, te, ge);
    exp_fc++;
    chk("f2_filt_cycles", a, 16);
    chk("f2_fcnt", 32'(sif.frame_cnt), 32'(exp_fc));

    // Stall 3 cycles at tap 7
    wait_idle();
    run_frame(7, 3, a, w, s, d, te, ge);
    exp_fc++;
    chk("stall_filt_cycles", a, 16);
    chk("stall_done_cycle", d, 20);
    chk("stall_tap_hold", te, 0);
    chk("stall_gate", ge, 0);
    chk("stall_fcnt", 32'(sif.frame_cnt), 32'(exp_fc));

    // clr together with stall during WCAL
    wait_idle();
    sif.head_flag = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sif.weight_cal_state) break;
    end
    chk("clr_reach_wcal", 32'(sif.weight_cal_state), 1);
    sif.clr = 1'b1;
    sif.stall = 1'b1;
    sif.head_flag = 1'b0;
    #1;
    chk("clr_stall_gate", 32'({sif.adap_filter_state, sif.weight_cal_state, sif.shift_data_state}), 0);
    @(negedge clk);
    sif.clr = 1'b0;
    sif.stall = 1'b0;
    #1;
    chk("clr_busy", 32'(sif.busy), 0);
    chk("clr_en", 32'({sif.adap_filter_state, sif.weight_cal_state, sif.shift_data_state, sif.done}), 0);
    chk("clr_tap", 32'(sif.tap_idx), 0);
    chk("clr_fcnt_kept", 32'(sif.frame_cnt), 32'(exp_fc));

    // Asynchronous reset mid-FILT at tap 9
    sif.head_flag = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sif.adap_filter_state && (sif.tap_idx == 4'd9)) break;
    end
    chk("arst_reach_tap9", 32'(sif.tap_idx), 9);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(sif.busy), 0);
    chk("arst_en", 32'({sif.adap_filter_state, sif.weight_cal_state, sif.shift_data_state}), 0);
    chk("arst_tap", 32'(sif.tap_idx), 0);
    chk("arst_fcnt", 32'(sif.frame_cnt), 0);
    sif.head_flag = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    run_frame(-1, 0, a, w, s, d, te, ge);
    chk("arst_new_filt", a, 16);
    chk("arst_new_taps", te, 0);
    chk("arst_new_done", d, 17);
    chk("arst_new_fcnt", 32'(sif.frame_cnt), 1);
    wait_idle();

    // Saturation with a 4-bit frame counter
    sat_to = 0;
    for (int f = 0; f < 17; f++) begin
      sat_if.head_flag = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        if (sat_if.done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) sat_to++;
      sat_if.head_flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        #1;
        if (!sat_if.busy) break;
      end
      @(negedge clk);
      #1;
      if (f == 13) chk("sat_fcnt_14", 32'(sat_if.frame_cnt), 14);
    end
    chk("sat_timeouts", sat_to, 0);
    chk("sat_fcnt_15", 32'(sat_if.frame_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
